// File: rtl/ldpc_ber_multi_regmap.sv
// Register map for a multi-channel LDPC BER tester: per-channel control, timed SW
// reset, atomic 64-bit counter snapshots and a shared failed-block event FIFO.
module ldpc_ber_multi_regmap #(
  parameter logic [31:0] SEED_ID       = 32'd0,
  parameter int          ADDRESS_WIDTH = 10,
  parameter int          NUM_CH        = 4,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic                     up_clk,
  input  logic                     up_resetn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [31:0]              up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_interrupt,
  output logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        ch_sw_resetn,
  output logic [16*NUM_CH-1:0]     ch_factor,
  output logic [8*NUM_CH-1:0]      ch_offset,
  input  logic [64*NUM_CH-1:0]     ch_finished_blocks,
  input  logic [64*NUM_CH-1:0]     ch_bit_errors,
  input  logic [64*NUM_CH-1:0]     ch_failed_blocks,
  input  logic [32*NUM_CH-1:0]     ch_in_flight,
  input  logic [NUM_CH-1:0]        ch_fail_valid,
  input  logic [64*NUM_CH-1:0]     ch_fail_data
);

  localparam int AW  = ADDRESS_WIDTH;
  localparam int AHW = ADDRESS_WIDTH - 4;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = PW + 1;
  localparam logic [31:0] VERSION = 32'h00020061;
  localparam logic [31:0] MAGIC   = 32'h4350444C;

  logic [31:0]       scratch;
  logic [1:0]        irq_enable;
  logic              irq_ovf;
  logic [15:0]       overflow_cnt;
  logic [4:0]        swr_cnt   [NUM_CH];
  logic [63:0]       snap_fin  [NUM_CH];
  logic [63:0]       snap_err  [NUM_CH];
  logic [63:0]       snap_fail [NUM_CH];
  logic [63:0]       hold      [NUM_CH];
  logic [NUM_CH-1:0] pending;

  logic [67:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [67:0]       head;
  logic              fifo_empty, fifo_full, push, pop;
  logic [3:0]        push_ch;
  logic [63:0]       push_data;
  logic [NUM_CH-1:0] drop;
  logic [3:0]        drop_cnt;
  logic [16:0]       ovf_sum;
  logic [1:0]        irq_status;
  logic [NUM_CH-1:0] ctrl_wr, cfg_wr, snap_wr;
  logic [31:0]       rdata_nxt;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];
  assign pop        = up_rreq && (up_raddr == AW'(13)) && !fifo_empty;
  assign irq_status = {irq_ovf, !fifo_empty};

  always_comb begin
    ctrl_wr = '0;
    cfg_wr  = '0;
    snap_wr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (up_wreq && up_waddr[AW-1:4] == AHW'(c + 2)) begin
        ctrl_wr[c] = (up_waddr[3:0] == 4'h0);
        cfg_wr[c]  = (up_waddr[3:0] == 4'h1);
        snap_wr[c] = (up_waddr[3:0] == 4'h2);
      end
    end
  end

  // Lowest-index pending channel wins; a pulse on the channel being pushed is not a drop
  always_comb begin
    push      = 1'b0;
    push_ch   = '0;
    push_data = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending[c]) begin
        push      = 1'b1;
        push_ch   = 4'(c);
        push_data = hold[c];
      end
    end
    if (fifo_full) push = 1'b0;
    drop     = '0;
    drop_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sw_resetn[c] && ch_fail_valid[c] && pending[c] && !(push && push_ch == 4'(c))) begin
        drop[c]  = 1'b1;
        drop_cnt = drop_cnt + 4'd1;
      end
    end
    ovf_sum = {1'b0, overflow_cnt} + {13'd0, drop_cnt};
  end

  always_comb begin
    rdata_nxt = '0;
    case (up_raddr)
      AW'(0):  rdata_nxt = VERSION;
      AW'(1):  rdata_nxt = SEED_ID;
      AW'(2):  rdata_nxt = scratch;
      AW'(3):  rdata_nxt = MAGIC;
      AW'(4):  rdata_nxt = 32'(NUM_CH);
      AW'(8):  rdata_nxt = {30'd0, irq_enable};
      AW'(9):  rdata_nxt = {30'd0, irq_status};
      AW'(10): rdata_nxt = {overflow_cnt, 16'(level)};
      AW'(11): rdata_nxt = fifo_empty ? '0 : {1'b1, 27'd0, head[67:64]};
      AW'(12): rdata_nxt = fifo_empty ? '0 : head[31:0];
      AW'(13): rdata_nxt = fifo_empty ? '0 : head[63:32];
      default: ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (up_raddr[AW-1:4] == AHW'(c + 2)) begin
        case (up_raddr[3:0])
          4'h0:    rdata_nxt = {30'd0, ch_sw_resetn[c], ch_en[c]};
          4'h1:    rdata_nxt = {8'd0, ch_offset[8*c +: 8], ch_factor[16*c +: 16]};
          4'h4:    rdata_nxt = snap_fin[c][31:0];
          4'h5:    rdata_nxt = snap_fin[c][63:32];
          4'h6:    rdata_nxt = snap_err[c][31:0];
          4'h7:    rdata_nxt = snap_err[c][63:32];
          4'h8:    rdata_nxt = snap_fail[c][31:0];
          4'h9:    rdata_nxt = snap_fail[c][63:32];
          4'hA:    rdata_nxt = ch_in_flight[32*c +: 32];
          default: ;
        endcase
      end
    end
  end

  // Overflow clear loses to a drop in the same cycle
  always_ff @(posedge up_clk) begin
    if (!up_resetn) begin
      up_wack      <= 1'b0;
      up_rack      <= 1'b0;
      up_rdata     <= '0;
      up_interrupt <= 1'b0;
      scratch      <= '0;
      irq_enable   <= '0;
      irq_ovf      <= 1'b0;
      overflow_cnt <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
    end else begin
      up_wack      <= up_wreq;
      up_rack      <= up_rreq;
      up_rdata     <= up_rreq ? rdata_nxt : '0;
      up_interrupt <= |(irq_status & irq_enable);
      if (up_wreq && up_waddr == AW'(2)) scratch <= up_wdata;
      if (up_wreq && up_waddr == AW'(8)) irq_enable <= up_wdata[1:0];
      if (|drop) irq_ovf <= 1'b1;
      else if (up_wreq && up_waddr == AW'(9) && up_wdata[1]) irq_ovf <= 1'b0;
      overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_resetn && push) fifo_mem[wr_ptr] <= {push_ch, push_data};
  end

  // ch_sw_resetn is registered from the counter so the low window starts one cycle after up_wack
  always_ff @(posedge up_clk) begin
    if (!up_resetn) begin
      ch_en        <= '0;
      ch_sw_resetn <= '0;
      ch_factor    <= '0;
      ch_offset    <= '0;
      pending      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        swr_cnt[c]   <= '0;
        snap_fin[c]  <= '0;
        snap_err[c]  <= '0;
        snap_fail[c] <= '0;
        hold[c]      <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_sw_resetn[c] <= (swr_cnt[c] == 5'd0);
        if (ctrl_wr[c] && up_wdata[1]) swr_cnt[c] <= 5'd16;
        else if (swr_cnt[c] != 5'd0) swr_cnt[c] <= swr_cnt[c] - 5'd1;
        if (ctrl_wr[c]) ch_en[c] <= up_wdata[0];
        if (cfg_wr[c]) begin
          ch_factor[16*c +: 16] <= up_wdata[15:0];
          ch_offset[8*c +: 8]   <= up_wdata[23:16];
        end
        if (snap_wr[c]) begin
          snap_fin[c]  <= ch_finished_blocks[64*c +: 64];
          snap_err[c]  <= ch_bit_errors[64*c +: 64];
          snap_fail[c] <= ch_failed_blocks[64*c +: 64];
        end
        if (!ch_sw_resetn[c]) pending[c] <= 1'b0;
        else if (ch_fail_valid[c] && !drop[c]) begin
          pending[c] <= 1'b1;
          hold[c]    <= ch_fail_data[64*c +: 64];
        end else if (push && push_ch == 4'(c)) pending[c] <= 1'b0;
      end
    end
  end

endmodule
